// File: rtl/rpn_pkg.sv
// Shared definitions for the RPN stack command engine: opcode and error
// encodings, the sequencing state set, and the command legality rule.
package rpn_pkg;

  localparam logic [2:0] OP_PUSH = 3'd0;
  localparam logic [2:0] OP_ADD  = 3'd1;
  localparam logic [2:0] OP_SUB  = 3'd2;
  localparam logic [2:0] OP_AND  = 3'd3;
  localparam logic [2:0] OP_OR   = 3'd4;
  localparam logic [2:0] OP_XOR  = 3'd5;
  localparam logic [2:0] OP_DUP  = 3'd6;
  localparam logic [2:0] OP_POP  = 3'd7;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_UNDER = 2'd1;
  localparam logic [1:0] ERR_OVER  = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ERR,
    S_POP_T,
    S_CAP_T,
    S_POP_N,
    S_CAP_N,
    S_PUSH_R,
    S_PUSH_D
  } state_t;

  // Returns the error a command would raise at the given occupancy.
  // Underflow is tested first so it wins when both could apply.
  function automatic logic [1:0] check_cmd(input logic [2:0] op,
                                           input int unsigned occ,
                                           input int unsigned cap);
    logic [1:0] e;
    e = ERR_NONE;
    case (op)
      OP_PUSH: if (occ >= cap) e = ERR_OVER;
      OP_DUP: begin
        if (occ < 1)         e = ERR_UNDER;
        else if (occ >= cap) e = ERR_OVER;
      end
      OP_POP:  if (occ < 1) e = ERR_UNDER;
      default: if (occ < 2) e = ERR_UNDER;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/rpn_stack_ctl_if.sv
// Command/result channel of the RPN engine. The master issues commands and
// consumes results; the slave is the engine.
interface rpn_stack_ctl_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) ();

  logic                         op_valid;
  logic                         op_ready;
  logic [2:0]                   opcode;
  logic [WIDTH-1:0]             imm;
  logic                         res_valid;
  logic [WIDTH-1:0]             res_data;
  logic                         done;
  logic [1:0]                   err;
  logic [$clog2(DEPTH+1)-1:0]   depth;

  modport master (
    output op_valid, opcode, imm,
    input  op_ready, res_valid, res_data, done, err, depth
  );

  modport slave (
    input  op_valid, opcode, imm,
    output op_ready, res_valid, res_data, done, err, depth
  );

endinterface

// File: rtl/rpn_alu.sv
// Combinational ALU for the RPN engine: computes N op T for the binary
// opcodes. Non-ALU opcodes yield zero.
module rpn_alu
  import rpn_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [2:0]       opcode,
  input  logic [WIDTH-1:0] n,
  input  logic [WIDTH-1:0] t,
  output logic [WIDTH-1:0] y
);

  // Operation select; add/sub wrap modulo 2^WIDTH with no flags.
  always_comb begin
    y = '0;
    case (opcode)
      OP_ADD:  y = n + t;
      OP_SUB:  y = n - t;
      OP_AND:  y = n & t;
      OP_OR:   y = n | t;
      OP_XOR:  y = n ^ t;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/rpn_stack_ctl.sv
// RPN command engine in front of a LIFO. Accepts one command at a time,
// sequences the LIFO pops/pushes it needs, applies the ALU, and tracks
// occupancy so that under/overflowing commands are rejected untouched.
module rpn_stack_ctl
  import rpn_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  rpn_stack_ctl_if.slave    cmd,
  output logic              lifo_push,
  output logic              lifo_pop,
  output logic [WIDTH-1:0]  lifo_din,
  input  logic [WIDTH-1:0]  lifo_dout
);

  localparam int DW = $clog2(DEPTH + 1);

  state_t           state_q, state_n;
  logic [2:0]       op_q, op_n;
  logic [WIDTH-1:0] t_q, t_n;
  logic [WIDTH-1:0] n_q, n_n;
  logic [WIDTH-1:0] din_q, din_n;
  logic [WIDTH-1:0] res_q, res_n;
  logic             push_q, push_n;
  logic             pop_q, pop_n;
  logic             done_q, done_n;
  logic             rv_q, rv_n;
  logic [1:0]       err_q, err_n;
  logic [1:0]       chk;
  logic [DW-1:0]    depth_q;
  logic [WIDTH-1:0] alu_n, alu_y;
  logic             pop_pass;

  // In CAP_N the next operand is still on lifo_dout; afterwards it is in N.
  assign alu_n = (state_q == S_CAP_N) ? lifo_dout : n_q;

  rpn_alu #(.WIDTH(WIDTH)) u_alu (
    .opcode (op_q),
    .n      (alu_n),
    .t      (t_q),
    .y      (alu_y)
  );

  // Legality of the command currently offered, judged at the present occupancy.
  always_comb chk = check_cmd(cmd.opcode, 32'(depth_q), DEPTH);

  // Next state plus the next value of every registered output.
  always_comb begin
    // NOTE: every target gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_n = state_q;
    op_n    = op_q;
    t_n     = t_q;
    n_n     = n_q;
    din_n   = din_q;
    res_n   = res_q;
    push_n  = 1'b0;
    pop_n   = 1'b0;
    done_n  = 1'b0;
    rv_n    = 1'b0;
    err_n   = ERR_NONE;

    case (state_q)
      S_IDLE: begin
        if (cmd.op_valid) begin
          op_n = cmd.opcode;
          if (chk != ERR_NONE) begin
            state_n = S_ERR;
            done_n  = 1'b1;
            err_n   = chk;
          end else if (cmd.opcode == OP_PUSH) begin
            state_n = S_PUSH_R;
            push_n  = 1'b1;
            din_n   = cmd.imm;
            done_n  = 1'b1;
          end else begin
            state_n = S_POP_T;
            pop_n   = 1'b1;
          end
        end
      end

      S_ERR: state_n = S_IDLE;

      S_POP_T: begin
        state_n = S_CAP_T;
        if (op_q == OP_POP) begin
          rv_n   = 1'b1;
          done_n = 1'b1;
        end
      end

      S_CAP_T: begin
        t_n = lifo_dout;
        if (op_q == OP_POP) begin
          state_n = S_IDLE;
          res_n   = lifo_dout;
        end else if (op_q == OP_DUP) begin
          state_n = S_PUSH_R;
          push_n  = 1'b1;
          din_n   = lifo_dout;
        end else begin
          state_n = S_POP_N;
          pop_n   = 1'b1;
        end
      end

      S_POP_N: state_n = S_CAP_N;

      S_CAP_N: begin
        n_n     = lifo_dout;
        state_n = S_PUSH_R;
        push_n  = 1'b1;
        din_n   = alu_y;
        res_n   = alu_y;
        rv_n    = 1'b1;
        done_n  = 1'b1;
      end

      S_PUSH_R: begin
        if (op_q == OP_DUP) begin
          state_n = S_PUSH_D;
          push_n  = 1'b1;
          done_n  = 1'b1;
        end else begin
          state_n = S_IDLE;
        end
      end

      S_PUSH_D: state_n = S_IDLE;
    endcase
  end

  // State, operand and output registers; reset aborts any command in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= OP_PUSH;
      t_q     <= '0;
      n_q     <= '0;
      din_q   <= '0;
      res_q   <= '0;
      push_q  <= 1'b0;
      pop_q   <= 1'b0;
      done_q  <= 1'b0;
      rv_q    <= 1'b0;
      err_q   <= ERR_NONE;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge
      // values regardless of statement order.
      state_q <= state_n;
      op_q    <= op_n;
      t_q     <= t_n;
      n_q     <= n_n;
      din_q   <= din_n;
      res_q   <= res_n;
      push_q  <= push_n;
      pop_q   <= pop_n;
      done_q  <= done_n;
      rv_q    <= rv_n;
      err_q   <= err_n;
    end
  end

  // Occupancy follows the LIFO: +1 at the end of a push cycle, -1 after a pop cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      depth_q <= '0;
    end else if (push_q) begin
      depth_q <= depth_q + DW'(1);
    end else if (pop_q) begin
      depth_q <= depth_q - DW'(1);
    end
  end

  // The popped value only appears on lifo_dout during CAP_T, so a POP result
  // is forwarded from the LIFO's registered output in that cycle and then held.
  assign pop_pass = (state_q == S_CAP_T) && (op_q == OP_POP);

  assign cmd.op_ready  = (state_q == S_IDLE);
  assign cmd.res_valid = rv_q;
  assign cmd.res_data  = pop_pass ? lifo_dout : res_q;
  assign cmd.done      = done_q;
  assign cmd.err       = err_q;
  assign cmd.depth     = depth_q;
  assign lifo_push     = push_q;
  assign lifo_pop      = pop_q;
  assign lifo_din      = din_q;

endmodule
